acc_drain_unit: RTL and testbench
=================================

Name: acc_drain_unit

Overview:
- Downstream consumer of the 4-entry accumulator FIFO (ACC FIFO) in the convolution engine.
- Pops a programmed number of partial sums from the FIFO and accumulates them in a wide signed register.
- Applies saturation to DataWidth, then optional ReLU.
- Presents one result per job to the NIOS-side output register through a valid/ready handshake.

Parameters:
DataWidth, 32, width of FIFO entries and of the output result (signed two's complement)
CountWidth, 8, width of the term counter and of NumTerms
SumWidth, 40, internal accumulator width; must be >= DataWidth+CountWidth (no internal overflow possible)

Ports:
clk  input  1  system clock, rising edge
aclr  input  1  asynchronous reset, active-low
clk_en  input  1  clock enable; when low, all state holds
Start  input  1  single-cycle job start request
NumTerms  input  CountWidth  number of partial sums to accumulate; sampled on accepted Start
ReluEn  input  1  enable ReLU on the result; sampled on accepted Start
FifoEmpty  input  1  Empty flag from the ACC FIFO
FifoData  input  DataWidth  show-ahead head entry of the ACC FIFO; valid whenever FifoEmpty=0
FifoPop  output  1  pop strobe to the ACC FIFO (combinational)
OutValid  output  1  result available
OutReady  input  1  downstream accepts the result
OutData  output  DataWidth  result (signed)
Busy  output  1  job in progress (state != IDLE)
Done  output  1  one-cycle pulse the cycle after result handshake
Sat  output  1  saturation occurred in the current or last job; sticky until next accepted Start

Behaviour:
- Reset (aclr=0, asynchronous): state=IDLE, sum=0, count=0, OutData=0, OutValid=0, Busy=0, Done=0, Sat=0. FifoPop=0 while aclr=0. Reset mid-job abandons the job; FIFO contents are untouched.
- clk_en=0: no register updates; FifoPop=0; handshake not accepted even if OutValid&OutReady; Done is not generated.
- States: IDLE, ACCUM, OUT.
- IDLE:
  - Start=1 and clk_en=1 -> latch NumTerms and ReluEn, sum=0, count=0, Sat=0.
  - Go to ACCUM if NumTerms != 0.
  - If NumTerms=0, go directly to OUT with OutData=0.
- ACCUM:
  - FifoPop = clk_en & ~FifoEmpty; the FIFO pointer advances the same edge.
  - On each pop: sum += sign-extended FifoData; count += 1.
  - FifoEmpty=1 is a bubble: sum and count hold.
  - On the pop where count == NumTerms-1, register the result from (sum + FifoData), go to OUT, and set OutValid=1 the next cycle.
  - No pop in the final cycle beyond NumTerms: exactly NumTerms entries are consumed.
- Result formation (registered, computed on the final pop):
  - Saturate sum to signed DataWidth: values above 2^(DataWidth-1)-1 become max; values below -2^(DataWidth-1) become min. Set Sat=1 on any clamp.
  - Then, if ReluEn=1, a negative value becomes 0.
- OUT:
  - OutValid=1; OutData stable; FifoPop=0.
  - OutValid & OutReady & clk_en -> next edge: OutValid=0, state=IDLE, Done=1 for one cycle.
- Start while Busy=1 is ignored (not queued).
- Start in the same cycle Done is high is accepted, because the state is already IDLE.
- Latency: Start at cycle 0 with a non-empty FIFO -> pops in cycles 1..N -> OutValid at cycle N+1.
- Throughput: one job per N+2 cycles minimum (N terms, one OUT cycle, one IDLE cycle).

Test Plan:
1. Hold FIFO at 10,-3,7,1; NumTerms=4, ReluEn=0; Start at cycle 0; OutReady=1 -> FifoPop high cycles 1-4, OutValid at cycle 5, OutData=15, Done at cycle 6, Sat=0.
2. Same data with FifoEmpty=1 during cycles 2-4 -> no pops in cycles 2-4, OutValid at cycle 8, OutData=15, exactly 4 pops total.
3. NumTerms=2, data 0x7FFFFFFF then 0x00000005 -> OutData=0x7FFFFFFF, Sat=1. Next job with data 1,1 -> Sat clears on Start, OutData=2.
4. Data -5, 2 with ReluEn=1 -> OutData=0. Repeat with ReluEn=0 -> OutData=0xFFFFFFFD.
5. Backpressure: OutReady=0 for 5 cycles in OUT, Start pulses during that time, FIFO non-empty -> OutValid held, OutData stable, FifoPop=0, Start ignored; OutReady=1 -> Done pulse, IDLE.
6. aclr low for 1 cycle after 2 of 4 pops -> all outputs 0 immediately, IDLE, no further pops. New Start with NumTerms=0 -> OutValid next cycle with OutData=0.

Source files
------------

// File: rtl/acc_drain_unit.sv
// Drains a programmed number of partial sums from the ACC FIFO, accumulates them,
// saturates to DataWidth, optionally applies ReLU and hands the result off via valid/ready.
module acc_drain_unit #(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned CountWidth = 8,
  parameter int unsigned SumWidth   = 40
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  clk_en,
  input  logic                  Start,
  input  logic [CountWidth-1:0] NumTerms,
  input  logic                  ReluEn,
  input  logic                  FifoEmpty,
  input  logic [DataWidth-1:0]  FifoData,
  output logic                  FifoPop,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [DataWidth-1:0]  OutData,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Sat
);

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  localparam logic signed [SumWidth-1:0] MaxVal =
    {{(SumWidth-DataWidth+1){1'b0}}, {(DataWidth-1){1'b1}}};
  localparam logic signed [SumWidth-1:0] MinVal =
    {{(SumWidth-DataWidth+1){1'b1}}, {(DataWidth-1){1'b0}}};

  state_t                      state_q, state_d;
  logic [CountWidth-1:0]       num_q, num_d;
  logic [CountWidth-1:0]       count_q, count_d;
  logic                        relu_q, relu_d;
  logic signed [SumWidth-1:0]  sum_q, sum_d;
  logic [DataWidth-1:0]        data_q, data_d;
  logic                        done_q, done_d;
  logic                        sat_q, sat_d;

  logic signed [SumWidth-1:0]  term;
  logic signed [SumWidth-1:0]  total;
  logic [DataWidth-1:0]        clamped;
  logic [DataWidth-1:0]        result;
  logic                        clamp;
  logic                        pop;

  // Result is formed from sum + current head so the final pop needs no extra cycle.
  always_comb begin
    term  = {{(SumWidth-DataWidth){FifoData[DataWidth-1]}}, FifoData};
    total = sum_q + term;
    clamp = 1'b0;
    if (total > MaxVal) begin
      clamped = MaxVal[DataWidth-1:0];
      clamp   = 1'b1;
    end else if (total < MinVal) begin
      clamped = MinVal[DataWidth-1:0];
      clamp   = 1'b1;
    end else begin
      clamped = total[DataWidth-1:0];
    end
    result = (relu_q && clamped[DataWidth-1]) ? '0 : clamped;
  end

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    count_d = count_q;
    relu_d  = relu_q;
    sum_d   = sum_q;
    data_d  = data_q;
    done_d  = done_q;
    sat_d   = sat_q;
    pop     = 1'b0;
    if (clk_en) begin
      done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            num_d   = NumTerms;
            relu_d  = ReluEn;
            sum_d   = '0;
            count_d = '0;
            sat_d   = 1'b0;
            if (NumTerms == '0) begin
              data_d  = '0;
              state_d = OUT;
            end else begin
              state_d = ACCUM;
            end
          end
        end
        ACCUM: begin
          if (!FifoEmpty) begin
            pop = 1'b1;
            if (count_q == num_q - CountWidth'(1)) begin
              data_d  = result;
              sat_d   = sat_q | clamp;
              state_d = OUT;
            end else begin
              sum_d   = total;
              count_d = count_q + CountWidth'(1);
            end
          end
        end
        OUT: begin
          if (OutReady) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q <= IDLE;
      num_q   <= '0;
      count_q <= '0;
      relu_q  <= 1'b0;
      sum_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      count_q <= count_d;
      relu_q  <= relu_d;
      sum_q   <= sum_d;
      data_q  <= data_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
    end
  end

  assign FifoPop  = pop & aclr;
  assign OutValid = (state_q == OUT);
  assign Busy     = (state_q != IDLE);
  assign OutData  = data_q;
  assign Done     = done_q;
  assign Sat      = sat_q;

endmodule

// File: tb/tb_acc_drain_unit.sv
// Directed vector bench for acc_drain_unit: per-cycle input/expected-output table plus
// hand-written backpressure and mid-job reset sequences.
module tb_acc_drain_unit;

  logic        clk = 1'b0;
  logic        aclr;
  logic        clk_en;
  logic        Start;
  logic [7:0]  NumTerms;
  logic        ReluEn;
  logic        FifoEmpty;
  logic [31:0] FifoData;
  logic        FifoPop;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutData;
  logic        Busy;
  logic        Done;
  logic        Sat;

  int checks   = 0;
  int failures = 0;

  acc_drain_unit #(.DataWidth(32), .CountWidth(8), .SumWidth(40)) dut (
    .clk(clk), .aclr(aclr), .clk_en(clk_en), .Start(Start), .NumTerms(NumTerms),
    .ReluEn(ReluEn), .FifoEmpty(FifoEmpty), .FifoData(FifoData), .FifoPop(FifoPop),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData), .Busy(Busy),
    .Done(Done), .Sat(Sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, st;
    logic [7:0]  num;
    logic        relu, emp;
    logic [31:0] data;
    logic        rdy;
    logic        pop, val, chk;
    logic [31:0] dat;
    logic        done, busy, sat;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(int en, int st, int num, int relu, int emp, int data, int rdy,
                              int pop, int val, int chk, int dat, int done, int busy, int sat);
    vec_t v;
    v.en = en[0]; v.st = st[0]; v.num = num[7:0]; v.relu = relu[0]; v.emp = emp[0];
    v.data = data; v.rdy = rdy[0];
    v.pop = pop[0]; v.val = val[0]; v.chk = chk[0]; v.dat = dat;
    v.done = done[0]; v.busy = busy[0]; v.sat = sat[0];
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drv(input vec_t v);
    clk_en = v.en; Start = v.st; NumTerms = v.num; ReluEn = v.relu;
    FifoEmpty = v.emp; FifoData = v.data; OutReady = v.rdy;
  endtask

  task automatic expect_o(input string tag, input vec_t v);
    cmp({tag, "_pop"},   32'(FifoPop),  32'(v.pop));
    cmp({tag, "_valid"}, 32'(OutValid), 32'(v.val));
    cmp({tag, "_done"},  32'(Done),     32'(v.done));
    cmp({tag, "_busy"},  32'(Busy),     32'(v.busy));
    cmp({tag, "_sat"},   32'(Sat),      32'(v.sat));
    if (v.chk) cmp({tag, "_data"}, OutData, v.dat);
  endtask

  // One table row per clock cycle: drive just after the edge, check mid-cycle.
  task automatic run_row(input string tag, input vec_t v);
    drv(v);
    #2;
    expect_o(tag, v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    aclr = 1'b0; clk_en = 1'b1; Start = 1'b0; NumTerms = '0; ReluEn = 1'b0;
    FifoEmpty = 1'b1; FifoData = '0; OutReady = 1'b0;
    #1;
    expect_o("reset", mk(1,0,0,0,1,0,0, 0,0,1,0,0,0,0));
    @(posedge clk); #1;
    aclr = 1'b1;
    @(posedge clk); #1;

    //            en st num re emp data         rdy  pop val chk dat          done busy sat
    // Job 1: 10,-3,7,1 -> 15
    vq.push_back(mk(1,1,4,0,1,0,           1,   0,0,0,0,           0,0,0));
    vq.push_back(mk(1,0,0,0,0,10,          1,   1,0,0,0,           0,1,0));
    vq.push_back(mk(1,0,0,0,0,-3,          1,   1,0,0,0,           0,1,0));
    vq.push_back(mk(1,0,0,0,0,7,           1,   1,0,0,0,           0,1,0));
    vq.push_back(mk(1,0,0,0,0,1,           1,   1,0,0,0,           0,1,0));
    vq.push_back(mk(1,0,0,0,0,99,          1,   0,1,1,15,          0,1,0));
    // Job 2: Start accepted in the Done cycle; empty bubbles in cycles 2-4
    vq.push_back(mk(1,1,4,0,1,0,           1,   0,0,0,0,           1,0,0));
    vq.push_back(mk(1,0,0,0,0,10,          1,   1,0,0,0,           0,1,0));
    vq.push_back(mk(1,0,0,0,1,55,          1,   0,0,0,0,           0,1,0));
    vq.push_back(mk(1,0,0,0,1,55,          1,   0,0,0,0,           0,1,0));
    vq.push_back(mk(1,0,0,0,1,55,          1,   0,0,0,0,           0,1,0));
    vq.push_back(mk(1,0,0,0,0,-3,          1,   1,0,0,0,           0,1,0));
    vq.push_back(mk(1,0,0,0,0,7,           1,   1,0,0,0,           0,1,0));
    vq.push_back(mk(1,0,0,0,0,1,           1,   1,0,0,0,           0,1,0));
    vq.push_back(mk(1,0,0,0,0,1,           1,   0,1,1,15,          0,1,0));
    // Job 3: positive saturation
    vq.push_back(mk(1,1,2,0,1,0,           1,   0,0,0,0,           1,0,0));
    vq.push_back(mk(1,0,0,0,0,32'h7FFFFFFF,1,   1,0,0,0,           0,1,0));
    vq.push_back(mk(1,0,0,0,0,5,           1,   1,0,0,0,           0,1,0));
    vq.push_back(mk(1,0,0,0,1,0,           1,   0,1,1,32'h7FFFFFFF,0,1,1));
    // Job 4: Sat clears on Start; clk_en low during ACCUM and during OUT handshake
    vq.push_back(mk(1,1,2,0,1,0,           1,   0,0,0,0,           1,0,1));
    vq.push_back(mk(1,0,0,0,0,1,           1,   1,0,0,0,           0,1,0));
    vq.push_back(mk(0,0,0,0,0,1,           1,   0,0,0,0,           0,1,0));
    vq.push_back(mk(1,0,0,0,0,1,           1,   1,0,0,0,           0,1,0));
    vq.push_back(mk(0,0,0,0,0,1,           1,   0,1,1,2,           0,1,0));
    vq.push_back(mk(1,0,0,0,0,1,           1,   0,1,1,2,           0,1,0));
    // Job 5: -5+2 with ReLU -> 0
    vq.push_back(mk(1,1,2,1,1,0,           1,   0,0,0,0,           1,0,0));
    vq.push_back(mk(1,0,0,0,0,-5,          1,   1,0,0,0,           0,1,0));
    vq.push_back(mk(1,0,0,0,0,2,           1,   1,0,0,0,           0,1,0));
    vq.push_back(mk(1,0,0,0,1,0,           1,   0,1,1,0,           0,1,0));
    // Job 6: same without ReLU -> -3
    vq.push_back(mk(1,1,2,0,1,0,           1,   0,0,0,0,           1,0,0));
    vq.push_back(mk(1,0,0,0,0,-5,          1,   1,0,0,0,           0,1,0));
    vq.push_back(mk(1,0,0,0,0,2,           1,   1,0,0,0,           0,1,0));
    vq.push_back(mk(1,0,0,0,1,0,           1,   0,1,1,32'hFFFFFFFD,0,1,0));
    // Job 7: negative saturation
    vq.push_back(mk(1,1,2,0,1,0,           1,   0,0,0,0,           1,0,0));
    vq.push_back(mk(1,0,0,0,0,32'h80000000,1,   1,0,0,0,           0,1,0));
    vq.push_back(mk(1,0,0,0,0,-1,          1,   1,0,0,0,           0,1,0));
    vq.push_back(mk(1,0,0,0,1,0,           1,   0,1,1,32'h80000000,0,1,1));
    vq.push_back(mk(1,0,0,0,1,0,           1,   0,0,0,0,           1,0,1));
    vq.push_back(mk(1,0,0,0,1,0,           1,   0,0,0,0,           0,0,1));

    for (int i = 0; i < vq.size(); i++)
      run_row($sformatf("row%0d", i), vq[i]);

    // Backpressure: OUT held 5 cycles with Start pulses and a non-empty FIFO
    run_row("bp_start", mk(1,1,1,0,0,9, 0,   0,0,0,0, 0,0,1));
    run_row("bp_pop",   mk(1,0,0,0,0,9, 0,   1,0,0,0, 0,1,0));
    for (int i = 0; i < 5; i++)
      run_row($sformatf("bp_hold%0d", i), mk(1,1,3,0,0,7, 0, 0,1,1,9, 0,1,0));
    run_row("bp_accept", mk(1,0,0,0,0,7, 1,   0,1,1,9, 0,1,0));
    run_row("bp_done",   mk(1,0,0,0,0,7, 1,   0,0,0,0, 1,0,0));
    run_row("bp_idle",   mk(1,0,0,0,0,7, 1,   0,0,0,0, 0,0,0));

    // Mid-job reset after 2 of 4 pops
    run_row("rst_start", mk(1,1,4,0,1,0, 1,   0,0,1,9, 0,0,0));
    run_row("rst_pop0",  mk(1,0,0,0,0,3, 1,   1,0,0,0, 0,1,0));
    run_row("rst_pop1",  mk(1,0,0,0,0,4, 1,   1,0,0,0, 0,1,0));
    drv(mk(1,0,0,0,0,5,1, 0,0,0,0,0,0,0));
    aclr = 1'b0;
    #1;
    expect_o("rst_async", mk(1,0,0,0,0,5,1, 0,0,1,0,0,0,0));
    @(posedge clk); #1;
    expect_o("rst_held",  mk(1,0,0,0,0,5,1, 0,0,1,0,0,0,0));
    aclr = 1'b1;
    run_row("rst_after", mk(1,0,0,0,0,5, 1,   0,0,1,0, 0,0,0));
    run_row("zero_start",mk(1,1,0,0,0,5, 1,   0,0,0,0, 0,0,0));
    run_row("zero_out",  mk(1,0,0,0,0,5, 1,   0,1,1,0, 0,1,0));
    run_row("zero_done", mk(1,0,0,0,0,5, 1,   0,0,1,0, 1,0,0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
